wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Shares the single writeback port (wb_*) of the RAT and ROB among NREQ functional units.
//  Each unit has a valid/ready handshake into its own small queue.
//  A round-robin arbiter picks one queue head per cycle and drives the registered wb_* outputs.
//  rob_flush discards every queued and in-flight result.
// PARAMETERS
//  NREQ   4  number of requesters (ALU0, ALU1, LSU, MUL/DIV); 2..8
//  DEPTH  2  entries per requester queue; power of two, >=2
// PORTS
//  clk         in   1         clock; all state updates on posedge
//  rst         in   1         synchronous reset, active-high
//  req_valid   in   NREQ      requester i presents a result
//  req_ready   out  NREQ      queue i can accept (= ~full_i)
//  req_error   in   NREQ      result i raised an exception
//  req_robid   in   NREQ*8    ROB id, slice [8i+7:8i]
//  req_rd      in   NREQ*6    dest; bit5 = writes a register, [4:0] = arch reg
//  req_result  in   NREQ*32   result value, slice [32i+31:32i]
//  rob_flush   in   1         squash everything in this block
//  wb_valid    out  1         writeback valid (registered)
//  wb_error    out  1         exception flag of granted entry
//  wb_robid    out  8         ROB id of granted entry
//  wb_rd       out  6         dest of granted entry
//  wb_result   out  32        value of granted entry
//  wb_grant    out  NREQ      one-hot source of the current wb_* (registered; debug/perf)
// BEHAVIOUR
//  Reset:
//   - Queues empty, so req_ready = all ones; wb_valid = 0, wb_grant = 0.
//   - wb_error/robid/rd/result = 0; RR pointer = NREQ-1, so requester 0 has top priority first.
//  Enqueue:
//   - On posedge, if req_valid[i] & req_ready[i] & ~rob_flush, write into queue i at its tail.
//   - req_valid while not ready is ignored (no drop, no error); the requester holds its data.
//  Arbitration (comb):
//   - Candidates are the non-empty queue heads.
//   - Pick the first candidate scanning ptr+1, ptr+2, ... modulo NREQ.
//  Output register (posedge):
//   - If a winner g exists and ~rob_flush: wb_* <= head_g, wb_valid <= 1, wb_grant <= 1<<g,
//     queue g is popped, ptr <= g.
//   - Otherwise wb_valid <= 0, wb_grant <= 0, ptr unchanged. wb_* data holds its last value.
//  No backpressure on wb_*: RAT and ROB always accept, so a winner is always retired from its queue.
//  Latency: accepted at edge T -> earliest wb_valid in cycle T+1, visible after edge T+1 (2 edges).
//  Throughput: 1 writeback per cycle in aggregate. Each queue sustains 1/cycle alone with DEPTH>=2.
//  Boundaries:
//   - Same-cycle push and pop on a full queue: pop frees a slot, but ready was 0 that cycle, so no push.
//     ready = ~full from registered state, never combinational from grant.
//   - Same-cycle push and pop on a non-full queue: both happen, count unchanged.
//   - Head/tail pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits, 0..DEPTH.
//   - rob_flush: all queues -> empty, wb_valid <= 0 on the same edge.
//     Enqueues on that edge are dropped. ptr unchanged.
//     A wb_valid already high during the flush cycle stays visible; ROB/RAT ignore it.
//   - rst overrides rob_flush and every enqueue/grant.
//   - req_error entries take part in arbitration like any other. wb_error is passed through
//     (the RAT does not write the speculative value; the ROB records the fault).
//   - rd[5]=0 entries still write back (ROB completion only).
//  Fairness: with all NREQ queues non-empty, each requester gets exactly 1 grant per NREQ cycles.
// STRUCTURE
//  Shared package/header (core_defs): ROBID_W=8, RD_W=6, XLEN=32, and the WB entry field layout
//   {error, robid, rd, result} = 47 bits.
//  Sub-module wb_fifo (DEPTH x 47 bits; push/pop/flush; full/empty), instantiated NREQ times via generate.
//  The round-robin picker stays inline in wb_arbiter as a for-loop over a doubled request vector.
// TESTING
//  1. Reset: after rst, req_ready=4'b1111, wb_valid=0, wb_grant=0.
//  2. Single requester: req 2 sends robid 8'h05, rd 6'h23, result 32'hDEADBEEF at edge T
//     -> after edge T+1: wb_valid=1, wb_grant=4'b0100, wb_rd=6'h23, wb_result=32'hDEADBEEF.
//  3. All four requesters sent one entry each on the same edge
//     -> grants 0,1,2,3 on consecutive cycles, then wb_valid=0.
//  4. Backpressure: req 1 holds valid for 3 cycles while the others saturate the port
//     -> req_ready[1]=0 after 2 accepts; no entry is lost or duplicated; order within req 1 is preserved.
//  5. Flush: 3 entries queued, rob_flush pulsed with a concurrent req 0 push
//     -> next cycle wb_valid=0, req_ready=4'b1111, the pushed entry never appears.
//  6. Error pass-through: req 3 sends req_error=1, robid 8'h7F -> wb_error=1, wb_robid=8'h7F.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback field widths and the queued entry layout.
package wb_arbiter_pkg;
    localparam int ROBID_W = 8;
    localparam int RD_W    = 6;
    localparam int XLEN    = 32;
    localparam int ENTRY_W = 1 + ROBID_W + RD_W + XLEN;

    typedef struct packed {
        logic               error;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [XLEN-1:0]    result;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-requester writeback queue with push/pop/flush and full/empty flags.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      head, tail;
    logic [CW-1:0]      count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= din;
    end

    assign dout  = mem[head];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin share of the single RAT/ROB writeback port among NREQ queued units.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_error,
    input  logic [NREQ*8-1:0]    req_robid,
    input  logic [NREQ*6-1:0]    req_rd,
    input  logic [NREQ*32-1:0]   req_result,
    input  logic                 rob_flush,
    output logic                 wb_valid,
    output logic                 wb_error,
    output logic [7:0]           wb_robid,
    output logic [5:0]           wb_rd,
    output logic [31:0]          wb_result,
    output logic [NREQ-1:0]      wb_grant
);
    localparam int PW = $clog2(NREQ);

    logic [ENTRY_W-1:0] head [NREQ];
    logic [NREQ-1:0]    full, empty;
    logic [2*NREQ-1:0]  dbl;
    logic [PW-1:0]      ptr, win;
    logic               found;
    wb_entry_t          wb_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_q
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (req_valid[i] && !full[i] && !rob_flush),
            .pop   (found && win == PW'(i) && !rob_flush),
            .flush (rob_flush),
            .din   ({req_error[i], req_robid[8*i+:8], req_rd[6*i+:6], req_result[32*i+:32]}),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign req_ready = ~full;
    assign dbl       = {~empty, ~empty};

    // Scanning the doubled vector from ptr+1 gives the wrap-around order without a modulo per step.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && dbl[int'(ptr) + k]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_grant <= '0;
            wb_q     <= '0;
            ptr      <= PW'(NREQ - 1);
        end else if (found && !rob_flush) begin
            wb_valid <= 1'b1;
            wb_grant <= NREQ'(1) << win;
            wb_q     <= wb_entry_t'(head[win]);
            ptr      <= win;
        end else begin
            wb_valid <= 1'b0;
            wb_grant <= '0;
        end
    end

    assign wb_error  = wb_q.error;
    assign wb_robid  = wb_q.robid;
    assign wb_rd     = wb_q.rd;
    assign wb_result = wb_q.result;
endmodule
